// File: rtl/move_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// move_scheduler_pkg
// Shared definitions for the move scheduler and its neighbours:
//   - 2-bit direction codes driven on move_dir
//   - key bit positions inside the packed key vector (direction keys sit at
//     the index equal to their direction code, so a direction can index the
//     key vector directly)
//   - direction FSM state type
//   - PS/2 set-2 scan codes, shared with the key-state decoder
//   - default timing parameters and the direction priority helper
// ---------------------------------------------------------------------------
package move_scheduler_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_KILL  = 4;
  localparam int NUM_KEYS  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DELAY  = 2'b01,
    ST_REPEAT = 2'b10
  } dir_state_t;

  // PS/2 set-2 make codes; arrows are preceded by the extended prefix
  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_LEFT       = 8'h6B;
  localparam logic [7:0] PS2_RIGHT      = 8'h74;
  localparam logic [7:0] PS2_UP         = 8'h75;
  localparam logic [7:0] PS2_DOWN       = 8'h72;
  localparam logic [7:0] PS2_KILL       = 8'h29;  // space bar

  localparam int DEF_DELAY_TICKS    = 8;
  localparam int DEF_REPEAT_TICKS   = 3;
  localparam int DEF_COOLDOWN_TICKS = 16;
  localparam int DEF_COMBO_WINDOW   = 30;
  localparam int DEF_COMBO_W        = 4;
  localparam int DEF_CNT_W          = 6;

  // Resolve a set of direction keys to one direction: up > down > left > right.
  function automatic logic [1:0] pick_dir(input logic [3:0] keys);
    if (keys[KEY_UP]) begin
      return DIR_UP;
    end else if (keys[KEY_DOWN]) begin
      return DIR_DOWN;
    end else if (keys[KEY_LEFT]) begin
      return DIR_LEFT;
    end else begin
      return DIR_RIGHT;
    end
  endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// ---------------------------------------------------------------------------
// move_scheduler_if
// Bundle between the key-state decoder / collision logic side and the move
// scheduler.
//   master : drives tick, key levels and hit; observes the scheduler outputs
//   slave  : the scheduler itself (consumes keys, produces moves/kill/combo)
// Signals:
//   tick        frame-rate strobe, one clk wide
//   key_*       held key levels
//   hit         one-clk pulse from collision logic
//   move_valid  one-clk move strobe, move_dir qualifies it
//   kill_fire   one-clk kill strobe, kill_ready = cooldown expired
//   combo       current combo count
// ---------------------------------------------------------------------------
interface move_scheduler_if #(
  parameter int COMBO_W = 4
);
  logic               tick;
  logic               key_left;
  logic               key_right;
  logic               key_up;
  logic               key_down;
  logic               key_kill;
  logic               hit;
  logic               move_valid;
  logic [1:0]         move_dir;
  logic               kill_fire;
  logic               kill_ready;
  logic [COMBO_W-1:0] combo;

  modport master (
    output tick, key_left, key_right, key_up, key_down, key_kill, hit,
    input  move_valid, move_dir, kill_fire, kill_ready, combo
  );

  modport slave (
    input  tick, key_left, key_right, key_up, key_down, key_kill, hit,
    output move_valid, move_dir, kill_fire, kill_ready, combo
  );
endinterface

// File: rtl/move_scheduler_key_edge.sv
// ---------------------------------------------------------------------------
// move_scheduler_key_edge
// Per-bit edge detector for held key levels. The previous level is kept in a
// register; rise/fall compare it with the current level, so an edge is seen
// in the same cycle the level first changes and a consumer registering on it
// responds one clk later.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (history clears to 0)
//   level     current key levels
//   rise      level & ~previous
//   fall      ~level & previous
// ---------------------------------------------------------------------------
module move_scheduler_key_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= level;
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign rise[gi] = level[gi] & ~prev_reg[gi];
      assign fall[gi] = ~level[gi] & prev_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
// Turns held key levels into timed game actions, all timing in frame ticks:
//   - direction moves: one-clk pulse on press, then typematic auto-repeat
//     (first repeat DELAY_TICKS after the press, then every REPEAT_TICKS);
//     the most recently pressed direction wins
//   - kill: one-clk fire on a fresh press, then COOLDOWN_TICKS lock-out
//   - combo: counts hits, cleared when COMBO_WINDOW ticks pass with no hit
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  move_scheduler_if.slave (tick, key levels, hit in;
//        move_valid/move_dir, kill_fire/kill_ready, combo out)
// ---------------------------------------------------------------------------
module move_scheduler
  import move_scheduler_pkg::*;
#(
  parameter int DELAY_TICKS    = DEF_DELAY_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS,
  parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS,
  parameter int COMBO_WINDOW   = DEF_COMBO_WINDOW,
  parameter int COMBO_W        = DEF_COMBO_W,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  move_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0]   DELAY_LAST  = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0]   REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0]   COOL_LOAD   = CNT_W'(COOLDOWN_TICKS);
  localparam logic [CNT_W-1:0]   WIN_LOAD    = CNT_W'(COMBO_WINDOW);
  localparam logic [COMBO_W-1:0] COMBO_MAX   = {COMBO_W{1'b1}};

  // -------------------------------------------------------------------------
  // Key edges
  // -------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] key_fall;

  assign key_level[KEY_LEFT]  = bus.key_left;
  assign key_level[KEY_RIGHT] = bus.key_right;
  assign key_level[KEY_UP]    = bus.key_up;
  assign key_level[KEY_DOWN]  = bus.key_down;
  assign key_level[KEY_KILL]  = bus.key_kill;

  move_scheduler_key_edge #(
    .W (NUM_KEYS)
  ) u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .level (key_level),
    .rise  (key_rise),
    .fall  (key_fall)
  );

  // Only a fresh press matters for kill; its release edge is not needed.
  logic unused_kill_fall;
  assign unused_kill_fall = key_fall[KEY_KILL];

  logic [3:0] dir_rise;
  logic [3:0] dir_held;
  assign dir_rise = key_rise[3:0];
  assign dir_held = key_level[3:0];

  // -------------------------------------------------------------------------
  // Direction FSM
  // -------------------------------------------------------------------------
  dir_state_t       state_reg;
  logic [1:0]       active_reg;
  logic [CNT_W-1:0] dir_cnt_reg;
  logic             move_valid_reg;
  logic [1:0]       move_dir_reg;
  logic             active_fall;

  // Direction codes equal key indices, so the active direction selects its
  // own key's release edge. Outside IDLE the active key is always held until
  // this edge, so the edge is exactly "active key released".
  assign active_fall = key_fall[active_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      active_reg     <= DIR_LEFT;
      dir_cnt_reg    <= '0;
      move_valid_reg <= 1'b0;
      move_dir_reg   <= DIR_LEFT;
    end else begin
      move_valid_reg <= 1'b0;
      if (|dir_rise) begin
        // New press wins over everything, including a tick this cycle.
        active_reg     <= pick_dir(dir_rise);
        move_dir_reg   <= pick_dir(dir_rise);
        move_valid_reg <= 1'b1;
        state_reg      <= ST_DELAY;
        dir_cnt_reg    <= '0;
      end else if (!(|dir_held)) begin
        state_reg   <= ST_IDLE;
        dir_cnt_reg <= '0;
      end else if ((state_reg != ST_IDLE) && active_fall) begin
        // Fall back to a still-held key; it waits a full delay, no pulse.
        active_reg  <= pick_dir(dir_held);
        state_reg   <= ST_DELAY;
        dir_cnt_reg <= '0;
      end else if (bus.tick) begin
        case (state_reg)
          ST_DELAY: begin
            if (dir_cnt_reg == DELAY_LAST) begin
              move_valid_reg <= 1'b1;
              move_dir_reg   <= active_reg;
              dir_cnt_reg    <= '0;
              state_reg      <= ST_REPEAT;
            end else begin
              dir_cnt_reg <= dir_cnt_reg + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (dir_cnt_reg == REPEAT_LAST) begin
              move_valid_reg <= 1'b1;
              move_dir_reg   <= active_reg;
              dir_cnt_reg    <= '0;
            end else begin
              dir_cnt_reg <= dir_cnt_reg + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Kill with cooldown
  // -------------------------------------------------------------------------
  logic             kill_fire_reg;
  logic             kill_ready_reg;
  logic [CNT_W-1:0] cool_cnt_reg;

  // A press during cooldown is simply dropped. Once the counter has reached
  // zero, ready returns on the following clk regardless of tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_fire_reg  <= 1'b0;
      kill_ready_reg <= 1'b1;
      cool_cnt_reg   <= '0;
    end else begin
      kill_fire_reg <= 1'b0;
      if (key_rise[KEY_KILL] && kill_ready_reg) begin
        kill_fire_reg  <= 1'b1;
        kill_ready_reg <= 1'b0;
        cool_cnt_reg   <= COOL_LOAD;
      end else if (!kill_ready_reg) begin
        if (cool_cnt_reg == '0) begin
          kill_ready_reg <= 1'b1;
        end else if (bus.tick) begin
          cool_cnt_reg <= cool_cnt_reg - 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Combo counter
  // -------------------------------------------------------------------------
  logic [COMBO_W-1:0] combo_reg;
  logic [CNT_W-1:0]   win_cnt_reg;

  // hit is checked first so a hit on the expiring tick extends the combo.
  // The combo clears on the very tick that brings the window to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      combo_reg   <= '0;
      win_cnt_reg <= '0;
    end else begin
      if (bus.hit) begin
        if (combo_reg != COMBO_MAX) begin
          combo_reg <= combo_reg + 1'b1;
        end
        win_cnt_reg <= WIN_LOAD;
      end else if (bus.tick && (combo_reg != '0)) begin
        if (win_cnt_reg <= CNT_W'(1)) begin
          combo_reg   <= '0;
          win_cnt_reg <= '0;
        end else begin
          win_cnt_reg <= win_cnt_reg - 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all registered)
  // -------------------------------------------------------------------------
  assign bus.move_valid = move_valid_reg;
  assign bus.move_dir   = move_dir_reg;
  assign bus.kill_fire  = kill_fire_reg;
  assign bus.kill_ready = kill_ready_reg;
  assign bus.combo      = combo_reg;

endmodule

// File: tb/tb_move_scheduler.sv
// ---------------------------------------------------------------------------
// tb_move_scheduler
// Self-checking bench: a table of hand-computed per-clk vectors, scenario
// sequences for the multi-cycle behaviour, and a randomized run compared
// against a tick-counting behavioural model.
// ---------------------------------------------------------------------------
module tb_move_scheduler;

  localparam int DELAY_TICKS    = 8;
  localparam int REPEAT_TICKS   = 3;
  localparam int COOLDOWN_TICKS = 16;
  localparam int COMBO_WINDOW   = 30;
  localparam int COMBO_W        = 4;
  localparam int CNT_W          = 6;
  localparam int COMBO_MAX      = (1 << COMBO_W) - 1;

  // key vector bit order: {kill, down, up, right, left}
  localparam logic [4:0] K_NONE  = 5'b00000;
  localparam logic [4:0] K_LEFT  = 5'b00001;
  localparam logic [4:0] K_RIGHT = 5'b00010;
  localparam logic [4:0] K_UP    = 5'b00100;
  localparam logic [4:0] K_KILL  = 5'b10000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  move_scheduler_if #(.COMBO_W(COMBO_W)) bus ();

  move_scheduler #(
    .DELAY_TICKS    (DELAY_TICKS),
    .REPEAT_TICKS   (REPEAT_TICKS),
    .COOLDOWN_TICKS (COOLDOWN_TICKS),
    .COMBO_WINDOW   (COMBO_WINDOW),
    .COMBO_W        (COMBO_W),
    .CNT_W          (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;
  logic [1:0] last_dir = 2'b00;

  // ---------------- behavioural model ----------------
  logic [4:0] m_prev;
  int         m_active;     // -1 when no direction is active
  int         m_ticks;      // ticks since the active direction was chosen
  logic       m_valid;
  logic [1:0] m_dir;
  logic       m_fire;
  logic       m_ready;
  int         m_cool;       // ticks since the last kill
  int         m_combo;
  int         m_since_hit;  // ticks since the last hit

  function automatic int pick(input logic [3:0] m);
    int order [4];
    order = '{2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin
      if (m[order[i]]) return order[i];
    end
    return -1;
  endfunction

  // A move is due on tick DELAY, then every REPEAT ticks after that.
  function automatic bit due(input int n);
    return (n == DELAY_TICKS) ||
           ((n > DELAY_TICKS) && (((n - DELAY_TICKS) % REPEAT_TICKS) == 0));
  endfunction

  task automatic model_reset();
    m_prev = '0; m_active = -1; m_ticks = 0; m_valid = 1'b0; m_dir = 2'b00;
    m_fire = 1'b0; m_ready = 1'b1; m_cool = 0; m_combo = 0; m_since_hit = 0;
  endtask

  task automatic model_step(input logic [4:0] k, input logic tk, input logic h);
    logic [4:0] r;
    r = k & ~m_prev;
    m_prev = k;
    m_valid = 1'b0;
    m_fire = 1'b0;
    if (r[3:0] != 4'b0) begin
      m_active = pick(r[3:0]);
      m_ticks = 0;
      m_valid = 1'b1;
      m_dir = 2'(m_active);
    end else if (k[3:0] == 4'b0) begin
      m_active = -1;
    end else if (m_active >= 0 && !k[m_active]) begin
      m_active = pick(k[3:0]);
      m_ticks = 0;
    end else if (m_active >= 0 && tk) begin
      m_ticks++;
      if (due(m_ticks)) begin
        m_valid = 1'b1;
        m_dir = 2'(m_active);
      end
    end
    if (r[4] && m_ready) begin
      m_fire = 1'b1;
      m_ready = 1'b0;
      m_cool = 0;
    end else if (!m_ready) begin
      if (m_cool >= COOLDOWN_TICKS) m_ready = 1'b1;
      else if (tk) m_cool++;
    end
    if (h) begin
      if (m_combo < COMBO_MAX) m_combo++;
      m_since_hit = 0;
    end else if (tk && m_combo != 0) begin
      m_since_hit++;
      if (m_since_hit >= COMBO_WINDOW) m_combo = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic drive(input logic [4:0] k, input logic tk, input logic h);
    bus.key_left  = k[0];
    bus.key_right = k[1];
    bus.key_up    = k[2];
    bus.key_down  = k[3];
    bus.key_kill  = k[4];
    bus.tick      = tk;
    bus.hit       = h;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    tests++;
    if (bus.move_valid !== m_valid || bus.move_dir !== m_dir ||
        bus.kill_fire !== m_fire || bus.kill_ready !== m_ready ||
        bus.combo !== COMBO_W'(m_combo)) begin
      fails++;
      $display("FAIL %s at %0t: got v=%0b d=%0b f=%0b r=%0b c=%0d expected v=%0b d=%0b f=%0b r=%0b c=%0d",
               name, $time, bus.move_valid, bus.move_dir, bus.kill_fire,
               bus.kill_ready, bus.combo, m_valid, m_dir, m_fire, m_ready, m_combo);
    end
  endtask

  // Called at posedge+1: drive, clock once, compare at posedge+1.
  task automatic step(input logic [4:0] k, input logic tk, input logic h, input string name);
    drive(k, tk, h);
    @(posedge clk);
    model_step(k, tk, h);
    #1;
    check_model(name);
    if (bus.move_valid === 1'b1) begin
      pulse_cnt++;
      last_dir = bus.move_dir;
    end
  endtask

  // n frame ticks, one tick every 4 clk
  task automatic run_ticks(input int n, input logic [4:0] k, input string name);
    for (int i = 0; i < n; i++) begin
      step(k, 1'b1, 1'b0, name);
      repeat (3) step(k, 1'b0, 1'b0, name);
    end
  endtask

  // Asynchronous reset: outputs must be at reset values before any edge.
  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    tests++;
    if (bus.move_valid !== 1'b0 || bus.move_dir !== 2'b00 || bus.kill_fire !== 1'b0 ||
        bus.kill_ready !== 1'b1 || bus.combo !== '0) begin
      fails++;
      $display("FAIL %s reset: got v=%0b d=%0b f=%0b r=%0b c=%0d expected v=0 d=0 f=0 r=1 c=0",
               name, bus.move_valid, bus.move_dir, bus.kill_fire, bus.kill_ready, bus.combo);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [4:0] keys;
    logic       tick;
    logic       hit;
    logic       ev;
    logic [1:0] ed;
    logic       ef;
    logic       er;
    logic [3:0] ec;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [4:0] rk;
    logic       rt;
    logic       rh;

    vecs[0]  = '{5'b00000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'd0};
    vecs[1]  = '{5'b00101, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'd0};
    vecs[2]  = '{5'b00101, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 4'd0};
    vecs[3]  = '{5'b10101, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{5'b10101, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0};
    vecs[5]  = '{5'b10101, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 4'd1};
    vecs[6]  = '{5'b10101, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 4'd2};
    vecs[7]  = '{5'b00101, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'd2};
    vecs[8]  = '{5'b10101, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'd2};
    vecs[9]  = '{5'b10001, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 4'd2};
    vecs[10] = '{5'b10011, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'd2};
    vecs[11] = '{5'b10000, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'd2};
    vecs[12] = '{5'b11000, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'd2};
    vecs[13] = '{5'b11000, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 4'd2};
    vecs[14] = '{5'b00000, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 4'd2};

    drive(K_NONE, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset("init");

    // ---- table ----
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].keys, vecs[i].tick, vecs[i].hit);
      @(posedge clk);
      #1;
      tests++;
      if (bus.move_valid !== vecs[i].ev || bus.move_dir !== vecs[i].ed ||
          bus.kill_fire !== vecs[i].ef || bus.kill_ready !== vecs[i].er ||
          bus.combo !== vecs[i].ec) begin
        fails++;
        $display("FAIL vec%0d: got v=%0b d=%0b f=%0b r=%0b c=%0d expected v=%0b d=%0b f=%0b r=%0b c=%0d",
                 i, bus.move_valid, bus.move_dir, bus.kill_fire, bus.kill_ready, bus.combo,
                 vecs[i].ev, vecs[i].ed, vecs[i].ef, vecs[i].er, vecs[i].ec);
      end
      $display("[TB] vec %0d keys=%05b tick=%0b hit=%0b -> v=%0b d=%0b f=%0b r=%0b c=%0d",
               i, vecs[i].keys, vecs[i].tick, vecs[i].hit, bus.move_valid, bus.move_dir,
               bus.kill_fire, bus.kill_ready, bus.combo);
    end

    // ---- 1: hold up, auto-repeat at ticks 8, 11, 14 ----
    do_reset("t1");
    step(K_UP, 1'b0, 1'b0, "t1_press");
    check_val("t1_first_valid", int'(bus.move_valid), 1);
    check_val("t1_first_dir", int'(bus.move_dir), 2);
    pulse_cnt = 0;
    run_ticks(DELAY_TICKS + 2 * REPEAT_TICKS, K_UP, "t1_hold");
    check_val("t1_repeat_pulses", pulse_cnt, 3);
    check_val("t1_repeat_dir", int'(last_dir), 2);
    pulse_cnt = 0;
    run_ticks(12, K_NONE, "t1_release");
    check_val("t1_after_release", pulse_cnt, 0);
    $display("[TB] seq1 typematic repeat done");

    // ---- 2: left held, right pressed at tick 5, then released ----
    do_reset("t2");
    step(K_LEFT, 1'b0, 1'b0, "t2_left");
    run_ticks(5, K_LEFT, "t2_hold_left");
    step(K_LEFT | K_RIGHT, 1'b0, 1'b0, "t2_right");
    check_val("t2_right_valid", int'(bus.move_valid), 1);
    check_val("t2_right_dir", int'(bus.move_dir), 1);
    run_ticks(3, K_LEFT | K_RIGHT, "t2_hold_both");
    pulse_cnt = 0;
    step(K_LEFT, 1'b0, 1'b0, "t2_release_right");
    run_ticks(DELAY_TICKS - 1, K_LEFT, "t2_fallback");
    check_val("t2_no_early_pulse", pulse_cnt, 0);
    run_ticks(1, K_LEFT, "t2_fallback_pulse");
    check_val("t2_fallback_pulses", pulse_cnt, 1);
    check_val("t2_fallback_dir", int'(last_dir), 0);
    $display("[TB] seq2 last-pressed wins and fallback done");

    // ---- 3: up and left rise together ----
    do_reset("t3");
    pulse_cnt = 0;
    step(K_UP | K_LEFT, 1'b0, 1'b0, "t3_both");
    check_val("t3_dir", int'(bus.move_dir), 2);
    step(K_UP | K_LEFT, 1'b0, 1'b0, "t3_hold");
    check_val("t3_single_pulse", pulse_cnt, 1);
    $display("[TB] seq3 simultaneous rise done");

    // ---- 4: kill and cooldown ----
    do_reset("t4");
    step(K_KILL, 1'b0, 1'b0, "t4_fire");
    check_val("t4_fire", int'(bus.kill_fire), 1);
    check_val("t4_ready_low", int'(bus.kill_ready), 0);
    step(K_KILL, 1'b0, 1'b0, "t4_held");
    check_val("t4_held_no_fire", int'(bus.kill_fire), 0);
    run_ticks(10, K_NONE, "t4_cool");
    step(K_KILL, 1'b0, 1'b0, "t4_drop");
    check_val("t4_dropped", int'(bus.kill_fire), 0);
    step(K_NONE, 1'b0, 1'b0, "t4_rel");
    run_ticks(COOLDOWN_TICKS - 11, K_NONE, "t4_cool2");
    check_val("t4_still_cool", int'(bus.kill_ready), 0);
    step(K_NONE, 1'b1, 1'b0, "t4_last_tick");
    check_val("t4_ready_not_yet", int'(bus.kill_ready), 0);
    step(K_NONE, 1'b0, 1'b0, "t4_ready");
    check_val("t4_ready_back", int'(bus.kill_ready), 1);
    step(K_KILL, 1'b0, 1'b0, "t4_refire");
    check_val("t4_refire", int'(bus.kill_fire), 1);
    $display("[TB] seq4 kill cooldown done");

    // ---- 5: combo window ----
    do_reset("t5");
    for (int i = 1; i <= 3; i++) begin
      step(K_NONE, 1'b0, 1'b1, "t5_hit");
      check_val("t5_combo_count", int'(bus.combo), i);
      if (i < 3) run_ticks(10, K_NONE, "t5_gap");
    end
    run_ticks(COMBO_WINDOW - 1, K_NONE, "t5_window");
    check_val("t5_alive", int'(bus.combo), 3);
    step(K_NONE, 1'b1, 1'b0, "t5_expire");
    check_val("t5_expired", int'(bus.combo), 0);
    step(K_NONE, 1'b0, 1'b1, "t5_hit_again");
    run_ticks(COMBO_WINDOW - 1, K_NONE, "t5_window2");
    step(K_NONE, 1'b1, 1'b1, "t5_hit_on_expiry");
    check_val("t5_hit_wins", int'(bus.combo), 2);
    for (int i = 0; i < 20; i++) step(K_NONE, 1'b0, 1'b1, "t5_burst");
    check_val("t5_saturate", int'(bus.combo), COMBO_MAX);
    $display("[TB] seq5 combo window done");

    // ---- 6: reset mid-REPEAT with combo and cooldown active ----
    do_reset("t6_pre");
    for (int i = 0; i < 5; i++) step(K_NONE, 1'b0, 1'b1, "t6_hits");
    step(K_KILL, 1'b0, 1'b0, "t6_kill");
    step(K_UP, 1'b0, 1'b0, "t6_up");
    run_ticks(DELAY_TICKS + 2, K_UP, "t6_repeat");
    check_val("t6_combo_before", int'(bus.combo), 5);
    check_val("t6_cool_before", int'(bus.kill_ready), 0);
    drive(K_NONE, 1'b0, 1'b0);
    do_reset("t6_mid");
    step(K_NONE, 1'b0, 1'b0, "t6_after");
    $display("[TB] seq6 mid-operation reset done");

    // ---- randomized run against the model ----
    do_reset("rand_start");
    rk = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 39) == 0) rk[$urandom_range(0, 4)] ^= 1'b1;
      rt = ($urandom_range(0, 3) == 0);
      rh = (c >= 2000 && c < 2030) ? 1'b1 : ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 999) == 0) begin
        drive(rk, rt, rh);
        do_reset("rand_reset");
      end
      step(rk, rt, rh, "rand");
    end
    $display("[TB] random run done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
